// File: rtl/cpu_pkg.sv
// Shared definitions for the EX stage of the 5-stage MIPS pipeline.
//   - aluop encodings driven by the main decoder in ID
//   - R-type funct codes understood by the ALU
//   - ALU-control opcode and multiplier FSM state enums
//   - small helpers for ALU-control decode and two's-complement magnitude
package cpu_pkg;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_RSVD  = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  typedef enum logic [2:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL
  } alu_ctl_e;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_RUN,
    MS_DONE
  } mul_state_e;

  function automatic alu_ctl_e alu_decode(input logic [1:0] aluop,
                                          input logic [5:0] funct);
    alu_ctl_e ctl;
    ctl = ALU_NOP;
    case (aluop)
      AOP_ADD: ctl = ALU_ADD;
      AOP_SUB: ctl = ALU_SUB;
      AOP_RTYPE: begin
        case (funct)
          FN_ADD:  ctl = ALU_ADD;
          FN_SUB:  ctl = ALU_SUB;
          FN_AND:  ctl = ALU_AND;
          FN_OR:   ctl = ALU_OR;
          FN_SLT:  ctl = ALU_SLT;
          FN_MUL:  ctl = ALU_MUL;
          default: ctl = ALU_NOP;
        endcase
      end
      default: ctl = ALU_NOP;
    endcase
    return ctl;
  endfunction

  // Magnitude of a signed 32-bit value; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/iter_mul.sv
// Iterative 32-step shift-add multiplier returning the low 32 bits of the
// signed product. Operands are converted to magnitudes at start and the
// result is negated when the operand signs differ.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        latch a/b and begin (only honoured in IDLE)
//   abort        drop any operation in flight and return to IDLE
//   a, b         signed operands
//   busy         high while stepping (RUN)
//   done         high for the single cycle the product is valid (DONE)
//   product_lo   low 32 bits of a*b, valid while done
//
// state   | meaning
// --------+--------------------------------------------------------
// MS_IDLE | waiting for start
// MS_RUN  | one shift-add step per cycle, count 0..31
// MS_DONE | product_lo valid for one cycle, then back to IDLE
module iter_mul
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product_lo
);

  mul_state_e        state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    case (state_q)
      MS_IDLE: begin
        if (start && !abort) begin
          state_d  = MS_RUN;
          count_d  = 5'd0;
          mcand_d  = abs32(a);
          mplier_d = abs32(b);
          acc_d    = '0;
          neg_d    = a[DATA_W-1] ^ b[DATA_W-1];
        end
      end
      MS_RUN: begin
        if (abort) begin
          state_d = MS_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (count_q == 5'd31) state_d = MS_DONE;
          else                  count_d = count_q + 5'd1;
        end
      end
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MS_IDLE;
      count_q  <= 5'd0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
    end
  end

  assign busy       = (state_q == MS_RUN);
  assign done       = (state_q == MS_DONE);
  assign product_lo = neg_q ? (~acc_q + 1'b1) : acc_q;

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: ALU-control decode, ALU, branch
// target add, destination select and the EX/MEM pipeline register. A signed
// multiply runs on iter_mul and stalls the front end until its product is
// ready.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid, flush            ID/EX holds a real instruction / kill EX
//   wb_ctl, m_ctl, regdst,
//   alusrc, aluop              control from ID/EX
//   npc, rdata1, rdata2,
//   s_extendout, instr_2016,
//   instr_1511                 data from ID/EX
//   stall                      hold PC, IF/ID and ID/EX (combinational)
//   wb_ctlout, branch, memread,
//   memwrite, zero, add_result,
//   alu_result, rdata2out,
//   five_bit_muxout            EX/MEM register contents
module execute_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [1:0]        wb_ctl,
  input  logic [2:0]        m_ctl,
  input  logic              regdst,
  input  logic              alusrc,
  input  logic [1:0]        aluop,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] s_extendout,
  input  logic [4:0]        instr_2016,
  input  logic [4:0]        instr_1511,
  output logic              stall,
  output logic [1:0]        wb_ctlout,
  output logic              branch,
  output logic              memread,
  output logic              memwrite,
  output logic              zero,
  output logic [DATA_W-1:0] add_result,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rdata2out,
  output logic [4:0]        five_bit_muxout
);

  localparam bit MUL_ON = (MUL_EN != 0);

  alu_ctl_e          alu_ctl;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] br_target;
  logic [4:0]        dest;
  logic              is_mul;
  logic              issue_mul;
  logic              stall_int;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  logic [1:0]        wb_q, wb_d;
  logic [2:0]        m_q, m_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [4:0]        dest_q, dest_d;

  always_comb begin
    alu_ctl   = alu_decode(aluop, s_extendout[5:0]);
    op_b      = alusrc ? s_extendout : rdata2;
    br_target = npc + (s_extendout << 2);
    dest      = regdst ? instr_1511 : instr_2016;
    alu_out   = '0;
    case (alu_ctl)
      ALU_ADD: alu_out = rdata1 + op_b;
      ALU_SUB: alu_out = rdata1 - op_b;
      ALU_AND: alu_out = rdata1 & op_b;
      ALU_OR:  alu_out = rdata1 | op_b;
      ALU_SLT: alu_out = ($signed(rdata1) < $signed(op_b)) ? 32'd1 : 32'd0;
      default: alu_out = '0;
    endcase
  end

  assign is_mul    = MUL_ON && (alu_ctl == ALU_MUL);
  // Issue only from IDLE; in DONE the same mul is still in ID/EX and must
  // not restart.
  assign issue_mul = is_mul && in_valid && !flush && !mul_busy && !mul_done;
  assign stall_int = !flush && (mul_busy || issue_mul);
  // Keep stall quiet while reset is held even if ID/EX shows a mul.
  assign stall     = rst_n && stall_int;

  iter_mul #(.DATA_W(DATA_W)) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (issue_mul),
    .abort      (flush),
    .a          (rdata1),
    .b          (rdata2),
    .busy       (mul_busy),
    .done       (mul_done),
    .product_lo (mul_product)
  );

  // Bubbles clear the controls and leave the data fields untouched.
  always_comb begin
    wb_d   = 2'b00;
    m_d    = 3'b000;
    zero_d = zero_q;
    add_d  = add_q;
    alu_d  = alu_q;
    rd2_d  = rd2_q;
    dest_d = dest_q;
    if (!flush && !stall_int && in_valid) begin
      wb_d   = wb_ctl;
      m_d    = m_ctl;
      alu_d  = mul_done ? mul_product : alu_out;
      zero_d = (alu_d == '0);
      add_d  = br_target;
      rd2_d  = rdata2;
      dest_d = dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q   <= 2'b00;
      m_q    <= 3'b000;
      zero_q <= 1'b0;
      add_q  <= '0;
      alu_q  <= '0;
      rd2_q  <= '0;
      dest_q <= 5'd0;
    end else begin
      wb_q   <= wb_d;
      m_q    <= m_d;
      zero_q <= zero_d;
      add_q  <= add_d;
      alu_q  <= alu_d;
      rd2_q  <= rd2_d;
      dest_q <= dest_d;
    end
  end

  assign wb_ctlout       = wb_q;
  assign branch          = m_q[2];
  assign memread         = m_q[1];
  assign memwrite        = m_q[0];
  assign zero            = zero_q;
  assign add_result      = add_q;
  assign alu_result      = alu_q;
  assign rdata2out       = rd2_q;
  assign five_bit_muxout = dest_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
EX stage of the 5-stage MIPS pipeline. It consumes the ID/EX latch contents and performs ALU control decode, the ALU operation, branch-target add and destination-register select. It holds the EX/MEM pipeline register that feeds the memory stage. An iterative 32-cycle multiplier stalls the front end through a stall/flush handshake.

Parameters:
DATA_W, 32, datapath width; only 32 supported.
MUL_EN, 1, 1 = funct 6'b011000 runs the iterative multiply; 0 = that funct yields result 0 with no stall.

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  ID/EX holds a real instruction; 0 = bubble.
flush  in  1  branch taken in MEM; kill the instruction in EX.
wb_ctl  in  2  {regwrite, memtoreg} from ID/EX.
m_ctl  in  3  {branch, memread, memwrite} from ID/EX.
regdst  in  1  1 = rd is the destination, 0 = rt.
alusrc  in  1  1 = operand B is the sign-extended immediate.
aluop  in  2  00 add, 01 sub, 10 R-type (funct), 11 reserved.
npc  in  32  PC+4.
rdata1  in  32  rs value.
rdata2  in  32  rt value.
s_extendout  in  32  sign-extended immediate; [5:0] is funct.
instr_2016  in  5  rt field.
instr_1511  in  5  rd field.
stall  out  1  hold PC, IF/ID and ID/EX this cycle.
wb_ctlout  out  2  registered wb_ctl.
branch  out  1  registered m_ctl[2].
memread  out  1  registered m_ctl[1].
memwrite  out  1  registered m_ctl[0].
zero  out  1  registered (alu_result == 0).
add_result  out  32  registered branch target.
alu_result  out  32  registered ALU/multiply result.
rdata2out  out  32  registered rdata2 (store data).
five_bit_muxout  out  5  registered destination register.

Behaviour:
- Reset (rst_n=0, async): every output 0; FSM to IDLE; multiplier count 0.
- ALU decode, aluop 00:
  - add.
- aluop 01:
  - sub.
- aluop 10, by funct:
  - 100000 add; 100010 sub; 100100 and; 100101 or.
  - 101010 slt, signed, result 1 or 0.
  - 011000 mul, low 32 bits of the signed product.
  - any other funct: result 0.
- aluop 11:
  - result 0.
- Operand B = alusrc ? s_extendout : rdata2.
- Add/sub wrap modulo 2^32; overflow is ignored.
- add_result = npc + (s_extendout << 2), modulo 2^32.
- five_bit_muxout = regdst ? instr_1511 : instr_2016.
- Single-cycle ops: one-cycle latency. The EX/MEM register loads at every edge where stall=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE with in_valid and mul decoded (MUL_EN=1): latch operands, count=0, go to RUN.
  - RUN: one shift-add step per cycle. At count==31 go to DONE, otherwise count+1.
  - DONE: stall=0; EX/MEM loads the product with the mul's own control, dest and rdata2; go to IDLE.
- stall is combinational: (state==RUN) | (state==IDLE & in_valid & is_mul & !flush). It is low in DONE.
- Mul issued in cycle T:
  - stall high cycles T..T+32.
  - DONE in cycle T+33.
  - EX/MEM shows the result from T+34.
- Stall cycles: EX/MEM loads a bubble.
  - wb_ctlout, branch, memread and memwrite are 0.
  - Data fields hold their previous values.
- in_valid=0: EX/MEM loads a bubble; data fields hold.
- flush=1 (highest priority after reset):
  - The next edge loads a bubble.
  - A mul in RUN or DONE aborts to IDLE and its result is discarded.
  - stall is 0 that cycle.
- Flush and mul issue in the same cycle: flush wins and the mul never starts.
- ID/EX contents are held by upstream while stall=1. This block samples rdata1/rdata2 only at mul issue.

Decomposition:
- Shared package cpu_pkg:
  - aluop encodings.
  - funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_MUL).
  - ALU-control opcode enum.
  - FSM state enum.
- Sub-module iter_mul:
  - Ports: start, a, b, busy, done, product_lo, abort.
  - 32-cycle shift-add with sign correction.
- ALU decode and the EX/MEM register stay in execute_stage.

Test Plan:
- Reset: rst_n low mid-run with arbitrary inputs -> all outputs 0, stall 0; after release, the first valid add completes normally.
- Add: aluop 10, funct 100000, rdata1=5, rdata2=7, regdst=1, rd=3 -> next edge alu_result=12, zero=0, five_bit_muxout=3, wb_ctlout passed through.
- Beq compare: aluop 01, rdata1=rdata2=9, m_ctl=3'b100, npc=0x100, imm=4 -> zero=1, branch=1, add_result=0x110.
- Slt and lw: slt rdata1=-1, rdata2=1 -> alu_result=1. Then lw, alusrc=1, rdata1=0x1000, imm=-4 -> alu_result=0x0FFC, memread=1.
- Multiply: mul 0xFFFFFFFD × 7 issued at cycle T -> stall high 33 cycles, EX/MEM controls 0 meanwhile, result 0xFFFFFFEB visible at T+34.
- Flush abort: flush at cycle T+10 of a mul -> stall drops that cycle, the next edge loads a bubble, FSM returns to IDLE, no product is ever written.
